mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-beat memory request/response port between two requesters: requester 0 is the front-end instruction fetch, requester 1 is the load/store unit.
- Arbitrates requests round-robin.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response to its owner.
- Drops fetch responses made stale by a branch redirect (flush).
- Sits between the core (fetch / LSU request paths) and the memory-side data_req/data_res channel.

Parameters:
- XLEN, 32, address width.
- DATA_W, 64, read/write data width.
- MAX_OUTST, 4, maximum outstanding accepted requests; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req0_valid_i / req1_valid_i  in  1  request valid, per requester
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle
- req0_addr_i / req1_addr_i  in  XLEN  request address
- req0_wr_i / req1_wr_i  in  1  1 = write, 0 = read
- req0_wdata_i / req1_wdata_i  in  DATA_W  write data
- flush0_i  in  1  discard all pending requester-0 responses
- mem_valid_o  out  1  memory request valid
- mem_ready_i  in  1  memory accepts request
- mem_addr_o  out  XLEN  granted address
- mem_wr_o  out  1  granted write flag
- mem_wdata_o  out  DATA_W  granted write data
- mem_rvalid_i  in  1  response valid (one per accepted request, in order)
- mem_rdata_i  in  DATA_W  response data
- res0_valid_o / res1_valid_o  out  1  routed response valid
- res0_data_o / res1_data_o  out  DATA_W  routed response data
- err_o  out  1  sticky spurious-response error
- perf_grant0_o / perf_grant1_o / perf_drop_o  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FIFO empty, count = 0, rr_q = 0, err_o = 0, counters = 0.
  - All valid/ready outputs 0 while in reset and in the first cycle after reset (count = 0, no inputs valid).
- Acceptance condition: can_acc = (count < MAX_OUTST), using the registered count. A response popping in the same cycle does NOT free a slot until the next cycle.
- Arbitration (combinational):
  - Only one requester valid: it is selected.
  - Both valid: requester rr_q is selected.
  - mem_valid_o = can_acc & (req0_valid_i | req1_valid_i).
  - mem_addr_o, mem_wr_o and mem_wdata_o come from the selected requester; they are zero when nothing is selected.
  - reqN_ready_o = selected==N & can_acc & mem_ready_i.
- Grant = mem_valid_o & mem_ready_i. On grant:
  - Push {id, drop=0} into the FIFO.
  - rr_q <= ~id.
  - With no grant, rr_q holds.
- Response (mem_rvalid_i = 1, FIFO not empty):
  - Pop the head entry.
  - If head.drop = 0, drive res{id}_valid_o = 1 and res{id}_data_o = mem_rdata_i combinationally, in the same cycle (zero latency).
  - If head.drop = 1, assert no valid.
  - res data outputs are 0 when their valid is low.
- Write requests also receive a response (acknowledge); it is routed identically.
- Flush (flush0_i = 1):
  - Sets drop on every FIFO entry with id = 0, effective for pops in the same cycle: a head response arriving with flush0_i is dropped.
  - A requester-0 request granted in the flush cycle is NOT marked drop.
  - Requester-1 entries are unaffected.
- Spurious response (mem_rvalid_i with FIFO empty): ignored, err_o <= 1, sticky until reset.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo MAX_OUTST.
- Reset mid-transaction discards all outstanding state; later responses count as spurious.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - perf_grant0_o / perf_grant1_o increment on each grant to that requester.
  - perf_drop_o increments on each dropped response.
  - All counters saturate at 2^32-1 and reset to 0.
- Undefined: the counter registers are not built; the three ports are tied to 0. All other behaviour is identical.

Test Plan:
- Reset: assert rst_ni = 0 mid-run with 2 outstanding -> all outputs 0 asynchronously. After release, first mem_rvalid_i -> err_o = 1.
- Fairness: both requesters valid every cycle, mem_ready_i = 1, responses returned each cycle -> grant ids 0,1,0,1,…; perf_grant0_o = perf_grant1_o = 4 after 8 grants (macro on).
- Back-pressure, MAX_OUTST = 4: req1 valid, no responses -> 4 grants, then req1_ready_o = 0. One mem_rvalid_i -> grant the following cycle, not the same cycle.
- Routing: grants 0 (addr 0x100), 1 (addr 0x200), 0 (addr 0x104); responses 0xA, 0xB, 0xC -> res0 gets 0xA, res1 gets 0xB, res0 gets 0xC, each in the cycle of mem_rvalid_i.
- Flush: outstanding ids 0,1,0; flush0_i pulsed, and a new req0 granted in the same cycle -> first and third responses dropped, res1 delivered, new req0 response delivered; perf_drop_o = 2.
- Flush coincident with a head response for id 0 -> that response dropped, no res0_valid_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-beat memory port between fetch (0) and LSU (1),
// with in-order response routing and fetch flush. Define MEM_ARB_PERF_CNT_EN to build the perf counters.
module mem_port_arbiter #(
    parameter int XLEN      = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [XLEN-1:0]   req0_addr_i,
    input  logic              req0_wr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [XLEN-1:0]   req1_addr_i,
    input  logic              req1_wr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic              flush0_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              res0_valid_o,
    output logic [DATA_W-1:0] res0_data_o,
    output logic              res1_valid_o,
    output logic [DATA_W-1:0] res1_data_o,
    output logic              err_o,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_drop_o
);

    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTST);

    logic [MAX_OUTST-1:0] id_q, id_d, drop_q, drop_d;
    logic [PW-1:0]        wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 rr_q, rr_d;
    logic                 err_q, err_d;

    logic canAcc, anyValid, sel, grant, fifoEmpty, pop, headId, headDrop, deliver;

    // Request side: outputs are forced quiet while reset is held, even with requesters valid.
    always_comb begin
        canAcc       = (count_q < MaxCnt);
        anyValid     = rst_ni & (req0_valid_i | req1_valid_i);
        sel          = (req0_valid_i & req1_valid_i) ? rr_q : req1_valid_i;
        mem_valid_o  = canAcc & anyValid;
        grant        = mem_valid_o & mem_ready_i;
        req0_ready_o = grant & ~sel;
        req1_ready_o = grant & sel;
        mem_addr_o   = '0;
        mem_wr_o     = 1'b0;
        mem_wdata_o  = '0;
        if (anyValid) begin
            mem_addr_o  = sel ? req1_addr_i  : req0_addr_i;
            mem_wr_o    = sel ? req1_wr_i    : req0_wr_i;
            mem_wdata_o = sel ? req1_wdata_i : req0_wdata_i;
        end
    end

    // A flush in the same cycle as a fetch-owned head response drops that response too.
    always_comb begin
        fifoEmpty    = (count_q == '0);
        pop          = mem_rvalid_i & ~fifoEmpty;
        headId       = id_q[rdPtr_q];
        headDrop     = drop_q[rdPtr_q] | (flush0_i & ~headId);
        deliver      = pop & ~headDrop;
        res0_valid_o = deliver & ~headId;
        res1_valid_o = deliver & headId;
        res0_data_o  = res0_valid_o ? mem_rdata_i : '0;
        res1_data_o  = res1_valid_o ? mem_rdata_i : '0;
        err_o        = err_q;
    end

    // The entry pushed this cycle is written after the flush mark so a fresh fetch survives.
    always_comb begin
        id_d   = id_q;
        drop_d = drop_q | (~id_q & {MAX_OUTST{flush0_i}});
        if (grant) begin
            id_d[wrPtr_q]   = sel;
            drop_d[wrPtr_q] = 1'b0;
        end
        wrPtr_d = wrPtr_q + PW'(grant);
        rdPtr_d = rdPtr_q + PW'(pop);
        count_d = count_q + CW'(grant) - CW'(pop);
        rr_d    = grant ? ~sel : rr_q;
        err_d   = err_q | (mem_rvalid_i & fifoEmpty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q    <= '0;
            drop_q  <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            drop_q  <= drop_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perfGrant0_q, perfGrant0_d, perfGrant1_q, perfGrant1_d, perfDrop_q, perfDrop_d;
    logic        dropEv;

    // Saturating event counters.
    always_comb begin
        dropEv       = pop & headDrop;
        perfGrant0_d = perfGrant0_q;
        perfGrant1_d = perfGrant1_q;
        perfDrop_d   = perfDrop_q;
        if (grant & ~sel & ~(&perfGrant0_q)) perfGrant0_d = perfGrant0_q + 32'd1;
        if (grant & sel & ~(&perfGrant1_q))  perfGrant1_d = perfGrant1_q + 32'd1;
        if (dropEv & ~(&perfDrop_q))         perfDrop_d   = perfDrop_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perfGrant0_q <= '0;
            perfGrant1_q <= '0;
            perfDrop_q   <= '0;
        end else begin
            perfGrant0_q <= perfGrant0_d;
            perfGrant1_q <= perfGrant1_d;
            perfDrop_q   <= perfDrop_d;
        end
    end

    assign perf_grant0_o = perfGrant0_q;
    assign perf_grant1_o = perfGrant1_q;
    assign perf_drop_o   = perfDrop_q;
`else
    assign perf_grant0_o = '0;
    assign perf_grant1_o = '0;
    assign perf_drop_o   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model of the outstanding-transaction list.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int DATA_W = 64;
    localparam int MAX_OUTST = 4;

    logic clk = 1'b0, rstN = 1'b0;
    logic req0Valid, req0Ready, req0Wr, req1Valid, req1Ready, req1Wr, flush0;
    logic [XLEN-1:0] req0Addr, req1Addr, memAddr;
    logic [DATA_W-1:0] req0Wdata, req1Wdata, memWdata, memRdata, res0Data, res1Data;
    logic memValid, memReady, memWr, memRvalid, res0Valid, res1Valid, err;
    logic [31:0] perfGrant0, perfGrant1, perfDrop;

    int nCompared = 0;
    int nMismatch = 0;

    typedef struct {bit id; bit drop;} entT;

    mem_port_arbiter #(.XLEN(XLEN), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req0_valid_i(req0Valid), .req0_ready_o(req0Ready), .req0_addr_i(req0Addr),
        .req0_wr_i(req0Wr), .req0_wdata_i(req0Wdata),
        .req1_valid_i(req1Valid), .req1_ready_o(req1Ready), .req1_addr_i(req1Addr),
        .req1_wr_i(req1Wr), .req1_wdata_i(req1Wdata),
        .flush0_i(flush0),
        .mem_valid_o(memValid), .mem_ready_i(memReady), .mem_addr_o(memAddr),
        .mem_wr_o(memWr), .mem_wdata_o(memWdata),
        .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
        .res0_valid_o(res0Valid), .res0_data_o(res0Data),
        .res1_valid_o(res1Valid), .res1_data_o(res1Data),
        .err_o(err),
        .perf_grant0_o(perfGrant0), .perf_grant1_o(perfGrant1), .perf_drop_o(perfDrop)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req0Valid = 0; req0Addr = '0; req0Wr = 0; req0Wdata = '0;
        req1Valid = 0; req1Addr = '0; req1Wr = 0; req1Wdata = '0;
        flush0 = 0; memReady = 0; memRvalid = 0; memRdata = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rstN = 0;
        cycle();
        cycle();
        rstN = 1;
    endtask

    task automatic test_reset();
        clearInputs();
        rstN = 0;
        #2;
        nCompared++; if ({memValid, req0Ready, req1Ready, res0Valid, res1Valid, err} !== 6'b0) begin nMismatch++; $display("[TB] FAIL reset_outputs: got %b want 000000", {memValid, req0Ready, req1Ready, res0Valid, res1Valid, err}); end
        nCompared++; if ({perfGrant0, perfGrant1, perfDrop} !== 96'b0) begin nMismatch++; $display("[TB] FAIL reset_perf: got %h want 0", {perfGrant0, perfGrant1, perfDrop}); end
        cycle();
        rstN = 1;
        #2;
        nCompared++; if ({memValid, req0Ready, req1Ready, err} !== 4'b0) begin nMismatch++; $display("[TB] FAIL first_cycle_after_reset: got %b want 0000", {memValid, req0Ready, req1Ready, err}); end
        cycle();
        req1Valid = 1; memReady = 1; req1Addr = 32'h40;
        cycle();
        cycle();
        rstN = 0;
        #1;
        nCompared++; if ({memValid, req0Ready, req1Ready, res0Valid, res1Valid, err} !== 6'b0) begin nMismatch++; $display("[TB] FAIL async_reset_outputs: got %b want 000000", {memValid, req0Ready, req1Ready, res0Valid, res1Valid, err}); end
        cycle();
        rstN = 1; req1Valid = 0; memRvalid = 1; memRdata = 64'h55;
        #2;
        nCompared++; if (res1Valid !== 1'b0) begin nMismatch++; $display("[TB] FAIL stale_resp_routed: got %b want 0", res1Valid); end
        cycle();
        memRvalid = 0;
        #1;
        nCompared++; if (err !== 1'b1) begin nMismatch++; $display("[TB] FAIL spurious_err: got %b want 1", err); end
    endtask

    task automatic test_fairness();
        logic [DATA_W-1:0] d;
        doReset();
        req0Valid = 1; req1Valid = 1; memReady = 1; req0Addr = 32'h10; req1Addr = 32'h20;
        for (int k = 0; k < 8; k++) begin
            memRvalid = (k > 0);
            d = {$urandom, $urandom};
            memRdata = d;
            #2;
            nCompared++; if ({req1Ready, req0Ready} !== ((k % 2) ? 2'b10 : 2'b01)) begin nMismatch++; $display("[TB] FAIL fair_grant%0d: got %b want id %0d", k, {req1Ready, req0Ready}, k % 2); end
            nCompared++; if (memAddr !== ((k % 2) ? 32'h20 : 32'h10)) begin nMismatch++; $display("[TB] FAIL fair_addr%0d: got %h", k, memAddr); end
            if (k > 0) begin
                nCompared++; if ({res1Valid, res0Valid} !== (((k - 1) % 2) ? 2'b10 : 2'b01)) begin nMismatch++; $display("[TB] FAIL fair_route%0d: got %b", k, {res1Valid, res0Valid}); end
                nCompared++; if ((((k - 1) % 2) ? res1Data : res0Data) !== d) begin nMismatch++; $display("[TB] FAIL fair_data%0d: got %h want %h", k, ((k - 1) % 2) ? res1Data : res0Data, d); end
            end
            cycle();
        end
        req0Valid = 0; req1Valid = 0; memRvalid = 1;
        #2;
        nCompared++; if ({res1Valid, res0Valid} !== 2'b10) begin nMismatch++; $display("[TB] FAIL fair_last_route: got %b want 10", {res1Valid, res0Valid}); end
        cycle();
        memRvalid = 0;
`ifdef MEM_ARB_PERF_CNT_EN
        nCompared++; if ({perfGrant0, perfGrant1} !== {32'd4, 32'd4}) begin nMismatch++; $display("[TB] FAIL fair_perf: got %0d/%0d want 4/4", perfGrant0, perfGrant1); end
`else
        nCompared++; if ({perfGrant0, perfGrant1} !== 64'd0) begin nMismatch++; $display("[TB] FAIL fair_perf_off: got %0d/%0d want 0/0", perfGrant0, perfGrant1); end
`endif
        nCompared++; if (err !== 1'b0) begin nMismatch++; $display("[TB] FAIL fair_err: got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        doReset();
        req1Valid = 1; memReady = 1; req1Addr = 32'h300;
        for (int k = 0; k < MAX_OUTST; k++) begin
            #2;
            nCompared++; if (req1Ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_accept%0d: got %b want 1", k, req1Ready); end
            cycle();
        end
        #2;
        nCompared++; if ({memValid, req1Ready} !== 2'b00) begin nMismatch++; $display("[TB] FAIL bp_full: got %b want 00", {memValid, req1Ready}); end
        cycle();
        memRvalid = 1; memRdata = 64'h77;
        #2;
        nCompared++; if ({res1Valid, req1Ready} !== 2'b10) begin nMismatch++; $display("[TB] FAIL bp_pop_same_cycle: got %b want 10", {res1Valid, req1Ready}); end
        cycle();
        memRvalid = 0;
        #2;
        nCompared++; if (req1Ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_slot_freed: got %b want 1", req1Ready); end
        cycle();
        req1Valid = 0; memRvalid = 1;
        repeat (MAX_OUTST) cycle();
        memRvalid = 0;
        #1;
        nCompared++; if (err !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_err: got %b want 0", err); end
    endtask

    task automatic test_routing();
        logic [XLEN-1:0] addrs [3] = '{32'h100, 32'h200, 32'h104};
        logic [DATA_W-1:0] datas [3] = '{64'hA, 64'hB, 64'hC};
        bit owners [3] = '{0, 1, 0};
        doReset();
        memReady = 1;
        for (int k = 0; k < 3; k++) begin
            req0Valid = !owners[k]; req1Valid = owners[k];
            req0Addr = addrs[k]; req1Addr = addrs[k];
            req1Wr = owners[k]; req1Wdata = 64'hDEAD_BEEF_0000_0001;
            #2;
            nCompared++; if (memAddr !== addrs[k]) begin nMismatch++; $display("[TB] FAIL route_addr%0d: got %h want %h", k, memAddr, addrs[k]); end
            nCompared++; if ({req1Ready, req0Ready} !== (owners[k] ? 2'b10 : 2'b01)) begin nMismatch++; $display("[TB] FAIL route_grant%0d: got %b", k, {req1Ready, req0Ready}); end
            nCompared++; if ({memWr, memWdata} !== (owners[k] ? {1'b1, 64'hDEAD_BEEF_0000_0001} : 65'd0)) begin nMismatch++; $display("[TB] FAIL route_wr%0d: got %b %h", k, memWr, memWdata); end
            cycle();
        end
        clearInputs();
        memReady = 1;
        for (int k = 0; k < 3; k++) begin
            memRvalid = 1; memRdata = datas[k];
            #2;
            nCompared++; if ({res1Valid, res0Valid} !== (owners[k] ? 2'b10 : 2'b01)) begin nMismatch++; $display("[TB] FAIL route_valid%0d: got %b", k, {res1Valid, res0Valid}); end
            nCompared++; if ({res0Data, res1Data} !== (owners[k] ? {64'd0, datas[k]} : {datas[k], 64'd0})) begin nMismatch++; $display("[TB] FAIL route_data%0d: got %h %h", k, res0Data, res1Data); end
            cycle();
        end
        memRvalid = 0;
    endtask

    task automatic test_flush();
        bit ids [3] = '{0, 1, 0};
        logic [1:0] expRes [4] = '{2'b00, 2'b10, 2'b00, 2'b01};
        doReset();
        memReady = 1;
        for (int k = 0; k < 3; k++) begin
            req0Valid = !ids[k]; req1Valid = ids[k];
            cycle();
        end
        req1Valid = 0; req0Valid = 1; flush0 = 1;
        #2;
        nCompared++; if (req0Ready !== 1'b1) begin nMismatch++; $display("[TB] FAIL flush_grant: got %b want 1", req0Ready); end
        cycle();
        req0Valid = 0; flush0 = 0;
        for (int k = 0; k < 4; k++) begin
            memRvalid = 1; memRdata = 64'(k + 1);
            #2;
            nCompared++; if ({res1Valid, res0Valid} !== expRes[k]) begin nMismatch++; $display("[TB] FAIL flush_resp%0d: got %b want %b", k, {res1Valid, res0Valid}, expRes[k]); end
            cycle();
        end
        memRvalid = 0;
`ifdef MEM_ARB_PERF_CNT_EN
        nCompared++; if (perfDrop !== 32'd2) begin nMismatch++; $display("[TB] FAIL flush_perf_drop: got %0d want 2", perfDrop); end
`else
        nCompared++; if (perfDrop !== 32'd0) begin nMismatch++; $display("[TB] FAIL flush_perf_drop_off: got %0d want 0", perfDrop); end
`endif
    endtask

    task automatic test_flush_head();
        doReset();
        memReady = 1; req0Valid = 1;
        cycle();
        req0Valid = 0; memRvalid = 1; flush0 = 1;
        #2;
        nCompared++; if ({res1Valid, res0Valid} !== 2'b00) begin nMismatch++; $display("[TB] FAIL flush_head_drop: got %b want 00", {res1Valid, res0Valid}); end
        cycle();
        flush0 = 0;
        #1;
        nCompared++; if (err !== 1'b0) begin nMismatch++; $display("[TB] FAIL flush_head_not_spurious: got %b want 0", err); end
        cycle();
        memRvalid = 0;
        #1;
        nCompared++; if (err !== 1'b1) begin nMismatch++; $display("[TB] FAIL flush_head_popped: got %b want 1", err); end
    endtask

    task automatic test_random();
        entT q[$];
        bit rrM = 0, errM = 0, sel, any, eValid, eRes0, eRes1, dropped;
        int g0 = 0, g1 = 0, dr = 0;
        logic [XLEN-1:0] eAddr;
        logic eWr;
        logic [DATA_W-1:0] eWdata;
        doReset();
        for (int c = 0; c < 400; c++) begin
            req0Valid = $urandom_range(0, 1); req1Valid = $urandom_range(0, 1);
            req0Addr = $urandom; req1Addr = $urandom;
            req0Wr = $urandom_range(0, 1); req1Wr = $urandom_range(0, 1);
            req0Wdata = {$urandom, $urandom}; req1Wdata = {$urandom, $urandom};
            memReady = ($urandom_range(0, 3) != 0);
            memRvalid = (q.size() > 0) ? $urandom_range(0, 1) : ($urandom_range(0, 19) == 0);
            flush0 = ($urandom_range(0, 9) == 0);
            memRdata = {$urandom, $urandom};
            any = req0Valid | req1Valid;
            sel = (req0Valid && req1Valid) ? rrM : req1Valid;
            eValid = any && (q.size() < MAX_OUTST);
            eAddr = !any ? '0 : (sel ? req1Addr : req0Addr);
            eWr = !any ? 1'b0 : (sel ? req1Wr : req0Wr);
            eWdata = !any ? '0 : (sel ? req1Wdata : req0Wdata);
            eRes0 = 0; eRes1 = 0; dropped = 0;
            if (memRvalid && q.size() > 0) begin
                dropped = q[0].drop || (flush0 && q[0].id == 0);
                if (dropped) dr++;
                else if (q[0].id) eRes1 = 1;
                else eRes0 = 1;
            end
            #2;
            nCompared++; if (memValid !== eValid) begin nMismatch++; $display("[TB] FAIL rnd_mem_valid c%0d: got %b want %b", c, memValid, eValid); end
            nCompared++; if ({req1Ready, req0Ready} !== {eValid && memReady && sel, eValid && memReady && !sel}) begin nMismatch++; $display("[TB] FAIL rnd_ready c%0d: got %b", c, {req1Ready, req0Ready}); end
            nCompared++; if ({memAddr, memWr, memWdata} !== {eAddr, eWr, eWdata}) begin nMismatch++; $display("[TB] FAIL rnd_mem_fields c%0d: got %h %b %h want %h %b %h", c, memAddr, memWr, memWdata, eAddr, eWr, eWdata); end
            nCompared++; if ({res1Valid, res0Valid} !== {eRes1, eRes0}) begin nMismatch++; $display("[TB] FAIL rnd_res_valid c%0d: got %b want %b", c, {res1Valid, res0Valid}, {eRes1, eRes0}); end
            nCompared++; if ({res0Data, res1Data} !== {eRes0 ? memRdata : 64'd0, eRes1 ? memRdata : 64'd0}) begin nMismatch++; $display("[TB] FAIL rnd_res_data c%0d: got %h %h", c, res0Data, res1Data); end
            nCompared++; if (err !== errM) begin nMismatch++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, err, errM); end
            if (memRvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else errM = 1;
            end
            if (flush0) foreach (q[i]) if (q[i].id == 0) q[i].drop = 1;
            if (eValid && memReady) begin
                q.push_back('{sel, 1'b0});
                rrM = ~sel;
                if (sel) g1++;
                else g0++;
            end
            cycle();
        end
        clearInputs();
`ifdef MEM_ARB_PERF_CNT_EN
        nCompared++; if ({perfGrant0, perfGrant1, perfDrop} !== {g0[31:0], g1[31:0], dr[31:0]}) begin nMismatch++; $display("[TB] FAIL rnd_perf: got %0d/%0d/%0d want %0d/%0d/%0d", perfGrant0, perfGrant1, perfDrop, g0, g1, dr); end
`else
        nCompared++; if ({perfGrant0, perfGrant1, perfDrop} !== 96'd0) begin nMismatch++; $display("[TB] FAIL rnd_perf_off: got %0d/%0d/%0d want 0", perfGrant0, perfGrant1, perfDrop); end
`endif
    endtask

    initial begin
        clearInputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_routing();
        test_flush();
        test_flush_head();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
